sc_mux_adder_n: RTL and testbench



---
 rtl/sc_mux_adder_n_if.sv | 27 ++
 rtl/sc_mux_adder_n.sv | 134 +++++++++++++
 tb/tb_sc_mux_adder_n.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sc_mux_adder_n_if.sv
// Stream/handshake bundle for sc_mux_adder_n: framing controls, one bit per input
// stream, and the selected output bit with its running ones count.
interface sc_mux_adder_n_if #(
    parameter int N_IN = 4,
    parameter int LEN  = 64
);
    localparam int CNT_W = $clog2(LEN + 1);

    logic             start;
    logic             in_valid;
    logic [N_IN-1:0]  in_bits;
    logic             out_valid;
    logic             out_bit;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ones_count;

    modport master (
        output start, in_valid, in_bits,
        input  out_valid, out_bit, busy, done, ones_count
    );

    modport slave (
        input  start, in_valid, in_bits,
        output out_valid, out_bit, busy, done, ones_count
    );
endinterface

// File: rtl/sc_mux_adder_n.sv
// N-input stochastic-computing scaled adder: picks one input bit per beat and counts ones.
// Define SC_ADDER_LFSR_EN for LFSR selection; otherwise selection is round-robin.
module sc_mux_adder_n #(
    parameter int          N_IN = 4,
    parameter int          LEN  = 64,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input logic          clk,
    input logic          rst_n,
    sc_mux_adder_n_if.slave bus
);
    localparam int CNT_W = $clog2(LEN + 1);
    localparam int SEL_W = $clog2(N_IN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] beat_cnt_r;
    logic [CNT_W-1:0] ones_r;
    logic             out_valid_r;
    logic             out_bit_r;
    logic             done_r;
    logic             busy_r;
    logic             accept_s;
    logic             last_s;
    logic             start_s;
    logic             sel_bit_s;
    logic [SEL_W-1:0] sel_s;

    assign accept_s  = (state_r == ST_RUN) && bus.in_valid;
    assign start_s   = (state_r == ST_IDLE) && bus.start;
    assign last_s    = (beat_cnt_r == CNT_W'(LEN - 1));
    assign sel_bit_s = bus.in_bits[sel_s];

`ifdef SC_ADDER_LFSR_EN
    logic [15:0] lfsr_r;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    // Scale the low LFSR byte into 0..N_IN-1; the LFSR persists across streams.
    assign sel_s = SEL_W'(({8'd0, lfsr_r[7:0]} * 16'(N_IN)) >> 8);

    // LFSR advances only on accepted beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= SEED;
        end else if (accept_s) begin
            lfsr_r <= lfsr_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`else
    logic [SEL_W-1:0] rr_r;

    assign sel_s = rr_r;

    // Round-robin selector, cleared on start, wraps at N_IN-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_r <= {SEL_W{1'b0}};
        end else if (start_s) begin
            rr_r <= {SEL_W{1'b0}};
        end else if (accept_s) begin
            rr_r <= (rr_r == SEL_W'(N_IN - 1)) ? {SEL_W{1'b0}} : rr_r + SEL_W'(1);
        end else begin
            rr_r <= rr_r;
        end
    end
`endif

    // Next-state logic for stream framing
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_RUN;
                else           state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (accept_s && last_s) state_s = ST_DONE;
                else                    state_s = ST_RUN;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // Output and counter registers; done coincides with the final out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_bit_r   <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            beat_cnt_r  <= {CNT_W{1'b0}};
            ones_r      <= {CNT_W{1'b0}};
        end else begin
            out_valid_r <= accept_s;
            done_r      <= accept_s && last_s;
            busy_r      <= (state_s != ST_IDLE);
            if (start_s) begin
                beat_cnt_r <= {CNT_W{1'b0}};
                ones_r     <= {CNT_W{1'b0}};
            end else if (accept_s) begin
                out_bit_r  <= sel_bit_s;
                beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                ones_r     <= ones_r + CNT_W'(sel_bit_s);
            end else begin
                beat_cnt_r <= beat_cnt_r;
                ones_r     <= ones_r;
            end
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.out_bit    = out_bit_r;
    assign bus.done       = done_r;
    assign bus.busy       = busy_r;
    assign bus.ones_count = ones_r;
endmodule

// File: tb/tb_sc_mux_adder_n.sv
// Directed, table-driven bench for sc_mux_adder_n with a per-beat selection model.
module tb_sc_mux_adder_n;
    localparam int          N_IN = 4;
    localparam int          LEN  = 64;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sc_mux_adder_n_if #(.N_IN(N_IN), .LEN(LEN)) bus ();

    sc_mux_adder_n #(.N_IN(N_IN), .LEN(LEN), .SEED(SEED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N_IN-1:0] pat;
        bit              gaps;
        bit              poke;
        int              exp_ones;
        int              exp_busy;
        string           name;
    } vec_t;

    vec_t        vecs[6];
    int          tests = 0;
    int          fails = 0;
    logic [15:0] lfsr_m;
    int          rr_m;
    int          ones_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_sel();
`ifdef SC_ADDER_LFSR_EN
        return int'(({8'd0, lfsr_m[7:0]} * 16'(N_IN)) >> 8);
`else
        return rr_m;
`endif
    endfunction

    task automatic model_advance();
`ifdef SC_ADDER_LFSR_EN
        lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
`else
        rr_m = (rr_m == N_IN - 1) ? 0 : rr_m + 1;
`endif
    endtask

    task automatic run_stream(input logic [N_IN-1:0] pat, input bit gaps, input bit poke,
                              input int stop_beats, input int exp_ones, input int exp_busy,
                              input string name);
        int beats;
        int busy_cnt;
        int exp_ones_final;
        bit sent;
        bit fin;
        logic exp_bit;
        beats    = 0;
        busy_cnt = 0;
        ones_m   = 0;
        rr_m     = 0;
        fin      = 1'b0;
        exp_bit  = 1'b0;
        bus.in_bits  = pat;
        bus.in_valid = 1'b0;
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (bus.busy) busy_cnt++;
        for (int c = 0; c < 400 && !fin; c++) begin
            sent = gaps ? (c % 2 == 1) : 1'b1;
            bus.in_valid = sent;
            bus.start    = poke && (c == 10);
            if (sent) begin
                exp_bit = pat[model_sel()];
                ones_m += int'(exp_bit);
                model_advance();
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            check({name, "_valid"}, 32'(bus.out_valid), 32'(sent));
            if (sent) begin
                beats++;
                check({name, "_bit"}, 32'(bus.out_bit), 32'(exp_bit));
                check({name, "_run_ones"}, 32'(bus.ones_count), 32'(ones_m));
            end
            check({name, "_done"}, 32'(bus.done), 32'(beats == LEN));
            if (beats == LEN || beats == stop_beats) fin = 1'b1;
        end
        bus.in_valid = 1'b0;
        if (!fin) check({name, "_timeout"}, 32'd0, 32'd1);
        if (stop_beats >= LEN) begin
`ifdef SC_ADDER_LFSR_EN
            exp_ones_final = (pat == '0 || pat == '1) ? exp_ones : ones_m;
`else
            exp_ones_final = exp_ones;
`endif
            check({name, "_ones"}, 32'(bus.ones_count), 32'(exp_ones_final));
            bus.start = poke;
            @(posedge clk); #1;
            bus.start = 1'b0;
            check({name, "_busy_fall"}, 32'(bus.busy), 32'd0);
            check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
            check({name, "_ones_hold"}, 32'(bus.ones_count), 32'(exp_ones_final));
            check({name, "_busy_span"}, 32'(busy_cnt), 32'(exp_busy));
        end
    endtask

    initial begin
        vecs[0] = '{pat: 4'b0001, gaps: 1'b0, poke: 1'b0, exp_ones: 16, exp_busy: 65,  name: "rr_0001"};
        vecs[1] = '{pat: 4'b0000, gaps: 1'b0, poke: 1'b0, exp_ones: 0,  exp_busy: 65,  name: "zeros"};
        vecs[2] = '{pat: 4'b1111, gaps: 1'b1, poke: 1'b0, exp_ones: 64, exp_busy: 129, name: "gaps_ones"};
        vecs[3] = '{pat: 4'b0101, gaps: 1'b0, poke: 1'b1, exp_ones: 32, exp_busy: 65,  name: "poke_0101"};
        vecs[4] = '{pat: 4'b0110, gaps: 1'b1, poke: 1'b0, exp_ones: 32, exp_busy: 129, name: "gaps_0110"};
        vecs[5] = '{pat: 4'b1000, gaps: 1'b0, poke: 1'b0, exp_ones: 16, exp_busy: 65,  name: "rr_1000"};

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_bits  = '0;
        lfsr_m       = SEED;
        rr_m         = 0;
        ones_m       = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_bit", 32'(bus.out_bit), 32'd0);
        check("rst_ones", 32'(bus.ones_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // in_valid while idle must not produce beats
        bus.in_valid = 1'b1;
        bus.in_bits  = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("idle_valid", 32'(bus.out_valid), 32'd0);
            check("idle_busy", 32'(bus.busy), 32'd0);
        end
        bus.in_valid = 1'b0;
        check("idle_ones", 32'(bus.ones_count), 32'd0);

        for (int v = 0; v < 6; v++) begin
            run_stream(vecs[v].pat, vecs[v].gaps, vecs[v].poke, LEN,
                       vecs[v].exp_ones, vecs[v].exp_busy, vecs[v].name);
        end

        // Reset mid-stream after 30 beats
        run_stream(4'b0101, 1'b0, 1'b0, 30, 0, 0, "partial");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_bit", 32'(bus.out_bit), 32'd0);
        check("midrst_ones", 32'(bus.ones_count), 32'd0);
        lfsr_m = SEED;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_no_done", 32'(bus.done), 32'd0);
        run_stream(4'b0101, 1'b0, 1'b0, LEN, 32, 65, "after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
